// File: rtl/adc_frame_capture.sv
// adc_frame_capture
// Multi-lane serial ADC frame receiver. Waits for a falling edge on nDRDY,
// shifts NUM_CH DOUT lanes MSB-first for FRAME_BITS clocks, then presents the
// assembled frame on a registered valid/ready output. Also provides input
// synchronisation, an enable/stop mode, sticky overrun and sync-error flags,
// and a wrapping completed-frame counter.
module adc_frame_capture #(
  parameter int NUM_CH      = 4,
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                              MCLK,
  input  logic                              RST,
  input  logic                              EN,
  input  logic                              nDRDY,
  input  logic [NUM_CH-1:0]                 DOUT,
  output logic [NUM_CH-1:0][FRAME_BITS-1:0] DATA,
  output logic                              DATA_VALID,
  input  logic                              DATA_READY,
  output logic                              OVERRUN,
  output logic                              SYNC_ERR,
  input  logic                              CLR_ERR,
  output logic [CNT_W-1:0]                  FRAME_CNT,
  output logic                              BUSY
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                             state;
  logic [BIT_W-1:0]                   bit_cnt;
  logic [NUM_CH-1:0][FRAME_BITS-1:0]  shift_reg;
  logic [NUM_CH-1:0][FRAME_BITS-1:0]  shift_next;

  logic [SYNC_STAGES-1:0]             ndrdy_pipe;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] dout_pipe;
  logic                               ndrdy_prev;
  logic                               d_n;
  logic [NUM_CH-1:0]                  d_dout;
  logic                               fall;

  assign d_n    = ndrdy_pipe[SYNC_STAGES-1];
  assign d_dout = dout_pipe[SYNC_STAGES-1];
  assign fall   = ~d_n & ndrdy_prev;

  // Equal-depth pipelines on nDRDY and DOUT keep the data lanes aligned with the ready edge
  always_ff @(posedge MCLK) begin
    if (RST) begin
      ndrdy_pipe <= '1;
      dout_pipe  <= '0;
      ndrdy_prev <= 1'b1;
    end else begin
      ndrdy_pipe[0] <= nDRDY;
      dout_pipe[0]  <= DOUT;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        ndrdy_pipe[s] <= ndrdy_pipe[s-1];
        dout_pipe[s]  <= dout_pipe[s-1];
      end
      ndrdy_prev <= d_n;
    end
  end

  // Each lane shifts left so the first captured bit ends up in the MSB after a full frame
  always_comb begin
    shift_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      shift_next[i] = {shift_reg[i][FRAME_BITS-2:0], d_dout[i]};
    end
  end

  // Capture FSM with registered frame output, handshake, error flags and frame counter
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
      SYNC_ERR   <= 1'b0;
      FRAME_CNT  <= '0;
      BUSY       <= 1'b0;
    end else begin
      if (DATA_VALID && DATA_READY) begin
        DATA_VALID <= 1'b0;
      end
      if (CLR_ERR) begin
        OVERRUN  <= 1'b0;
        SYNC_ERR <= 1'b0;
      end
      if (fall && (state == SHIFT || state == DONE)) begin
        SYNC_ERR <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (EN) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (fall) begin
            shift_reg <= shift_next;
            bit_cnt   <= BIT_W'(1);
            state     <= SHIFT;
            BUSY      <= 1'b1;
          end else if (!EN) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          bit_cnt   <= bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= DONE;
            BUSY  <= 1'b0;
          end
        end
        DONE: begin
          DATA       <= shift_reg;
          DATA_VALID <= 1'b1;
          if (DATA_VALID && !DATA_READY) begin
            OVERRUN <= 1'b1;
          end
          FRAME_CNT <= FRAME_CNT + CNT_W'(1);
          bit_cnt   <= '0;
          state     <= EN ? WAIT : IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb_adc_frame_capture
// Drives ADC-style frames (nDRDY fall plus MSB-first lanes) into two
// configurations of adc_frame_capture and compares the outputs against a
// frame-level model of the receiver's handshake, flags and counter.
`timescale 1ns/1ps
module tb_adc_frame_capture;

  localparam int NCH   = 4;
  localparam int FB    = 64;
  localparam int CW    = 16;
  localparam int NCH_B = 8;
  localparam int FB_B  = 24;
  localparam int CW_B  = 4;

  typedef logic [NCH-1:0][FB-1:0]     frame_t;
  typedef logic [NCH_B-1:0][FB_B-1:0] frame_b_t;

  logic MCLK = 1'b0;

  // Free-running master clock shared by both receivers
  always #5 MCLK = ~MCLK;

  logic            rst, en, ndrdy, data_ready, clr_err;
  logic [NCH-1:0]  dout;
  frame_t          data;
  logic            data_valid, overrun, sync_err, busy;
  logic [CW-1:0]   frame_cnt;

  logic             rst_b, en_b, ndrdy_b, data_ready_b, clr_err_b;
  logic [NCH_B-1:0] dout_b;
  frame_b_t         data_b;
  logic             data_valid_b, overrun_b, sync_err_b, busy_b;
  logic [CW_B-1:0]  frame_cnt_b;

  adc_frame_capture #(.NUM_CH(NCH), .FRAME_BITS(FB), .SYNC_STAGES(2), .CNT_W(CW)) dut (
    .MCLK(MCLK), .RST(rst), .EN(en), .nDRDY(ndrdy), .DOUT(dout),
    .DATA(data), .DATA_VALID(data_valid), .DATA_READY(data_ready),
    .OVERRUN(overrun), .SYNC_ERR(sync_err), .CLR_ERR(clr_err),
    .FRAME_CNT(frame_cnt), .BUSY(busy)
  );

  adc_frame_capture #(.NUM_CH(NCH_B), .FRAME_BITS(FB_B), .SYNC_STAGES(2), .CNT_W(CW_B)) dut_b (
    .MCLK(MCLK), .RST(rst_b), .EN(en_b), .nDRDY(ndrdy_b), .DOUT(dout_b),
    .DATA(data_b), .DATA_VALID(data_valid_b), .DATA_READY(data_ready_b),
    .OVERRUN(overrun_b), .SYNC_ERR(sync_err_b), .CLR_ERR(clr_err_b),
    .FRAME_CNT(frame_cnt_b), .BUSY(busy_b)
  );

  int checks = 0;
  int errors = 0;

  frame_t m_data;
  bit     m_valid, m_overrun, m_sync;
  int     m_cnt;

  frame_t   w1, wa, wb, wc, wd, we, wf, wg, wh, wr;
  frame_b_t wbb;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    m_data    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_sync    = 1'b0;
    m_cnt     = 0;
  endfunction

  function automatic void modelDone(input frame_t w, input bit ready);
    if (m_valid && !ready) m_overrun = 1'b1;
    m_data  = w;
    m_valid = 1'b1;
    m_cnt   = (m_cnt + 1) % (1 << CW);
  endfunction

  function automatic frame_t randFrame();
    frame_t w;
    for (int i = 0; i < NCH; i++) w[i] = {$urandom(), $urandom()};
    return w;
  endfunction

  task automatic checkAll(input string tag);
    for (int i = 0; i < NCH; i++)
      checkOutput($sformatf("%s_data%0d", tag, i), data[i], m_data[i]);
    checkOutput($sformatf("%s_valid", tag), 64'(data_valid), 64'(m_valid));
    checkOutput($sformatf("%s_overrun", tag), 64'(overrun), 64'(m_overrun));
    checkOutput($sformatf("%s_syncerr", tag), 64'(sync_err), 64'(m_sync));
    checkOutput($sformatf("%s_cnt", tag), 64'(frame_cnt), 64'(m_cnt));
  endtask

  // Pin-level frame: nDRDY low for 4 cycles, lanes MSB-first, optional extra fall / EN drop / reset
  task automatic applyStimulus(input frame_t w, input int glitch_at, input int en_drop_at,
                               input int rst_at, input bit expect_capture);
    for (int j = 0; j < FB; j++) begin
      @(negedge MCLK);
      if (j == 10) checkOutput("busy_mid", 64'(busy), 64'(expect_capture));
      if (rst_at >= 0 && j == rst_at + 2) begin
        modelReset();
        checkAll("in_reset");
        checkOutput("busy_in_reset", 64'(busy), 64'(0));
      end
      ndrdy = !(j < 4 || (glitch_at >= 0 && (j == glitch_at || j == glitch_at + 1)));
      for (int i = 0; i < NCH; i++) dout[i] = w[i][FB-1-j];
      if (j == en_drop_at) en = 1'b0;
      if (rst_at >= 0) rst = (j == rst_at || j == rst_at + 1);
    end
  endtask

  // Frame output is due at pin-fall + 2 sync stages + FB bits + 1 registered cycle
  task automatic finishFrame(input frame_t w, input bit expect_capture, input bit raise_ready);
    @(negedge MCLK);
    @(negedge MCLK);
    checkOutput("busy_last_bit", 64'(busy), 64'(expect_capture));
    @(negedge MCLK);
    checkOutput("busy_done", 64'(busy), 64'(0));
    checkOutput("valid_pre", 64'(data_valid), 64'(m_valid));
    if (raise_ready) data_ready = 1'b1;
    @(negedge MCLK);
    if (expect_capture) modelDone(w, data_ready);
    checkAll("done");
    @(negedge MCLK);
    if (data_ready) m_valid = 1'b0;
    checkOutput("valid_post", 64'(data_valid), 64'(m_valid));
  endtask

  task automatic clearErrors(input string tag);
    @(negedge MCLK);
    clr_err = 1'b1;
    @(negedge MCLK);
    m_overrun = 1'b0;
    m_sync    = 1'b0;
    checkAll(tag);
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ndrdy = 1'b1; dout = '0; data_ready = 1'b0; clr_err = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; ndrdy_b = 1'b1; dout_b = '0; data_ready_b = 1'b1; clr_err_b = 1'b0;
    modelReset();
    repeat (3) @(negedge MCLK);
    checkAll("reset");
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("b_reset_cnt", 64'(frame_cnt_b), 64'(0));
    checkOutput("b_reset_valid", 64'(data_valid_b), 64'(0));
    rst = 1'b0; rst_b = 1'b0; en = 1'b1; en_b = 1'b1; data_ready = 1'b1;
    repeat (2) @(negedge MCLK);

    $display("[TB] fixed-pattern frame");
    w1[0] = 64'hDEADBEEF_01234567;
    w1[1] = '1;
    w1[2] = '0;
    w1[3] = 64'hAAAA_AAAA_AAAA_AAAA;
    applyStimulus(w1, -1, -1, -1, 1'b1);
    finishFrame(w1, 1'b1, 1'b0);

    $display("[TB] back-to-back frames without ready");
    @(negedge MCLK);
    data_ready = 1'b0;
    wa = randFrame();
    wb = randFrame();
    applyStimulus(wa, -1, -1, -1, 1'b1);
    repeat (2) @(negedge MCLK);
    fork
      applyStimulus(wb, -1, -1, -1, 1'b1);
      begin
        @(negedge MCLK);
        checkOutput("a_valid_pre", 64'(data_valid), 64'(0));
        @(negedge MCLK);
        modelDone(wa, 1'b0);
        checkAll("frame_a");
      end
    join
    finishFrame(wb, 1'b1, 1'b0);
    clearErrors("clr_overrun");

    $display("[TB] ready in the same cycle as done");
    wc = randFrame();
    @(negedge MCLK);
    applyStimulus(wc, -1, -1, -1, 1'b1);
    finishFrame(wc, 1'b1, 1'b1);

    $display("[TB] extra nDRDY fall mid-frame");
    wd = randFrame();
    @(negedge MCLK);
    applyStimulus(wd, 20, -1, -1, 1'b1);
    m_sync = 1'b1;
    finishFrame(wd, 1'b1, 1'b0);
    clearErrors("clr_sync");

    $display("[TB] enable dropped mid-frame");
    we = randFrame();
    wf = randFrame();
    @(negedge MCLK);
    applyStimulus(we, -1, 30, -1, 1'b1);
    finishFrame(we, 1'b1, 1'b0);
    repeat (3) @(negedge MCLK);
    applyStimulus(wf, -1, -1, -1, 1'b0);
    finishFrame(wf, 1'b0, 1'b0);
    en = 1'b1;

    $display("[TB] reset mid-frame then clean frame");
    wg = randFrame();
    wh = randFrame();
    repeat (2) @(negedge MCLK);
    applyStimulus(wg, -1, -1, 40, 1'b1);
    finishFrame(wg, 1'b0, 1'b0);
    @(negedge MCLK);
    applyStimulus(wh, -1, -1, -1, 1'b1);
    finishFrame(wh, 1'b1, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      int  g;
      bit  r;
      r = 1'($urandom_range(0, 1));
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 55)) : -1;
      wr = randFrame();
      @(negedge MCLK);
      data_ready = r;
      if (r) m_valid = 1'b0;
      applyStimulus(wr, g, -1, -1, 1'b1);
      if (g >= 0) m_sync = 1'b1;
      finishFrame(wr, 1'b1, 1'b0);
    end

    $display("[TB] 8x24 receiver, counter wrap");
    for (int f = 0; f < 17; f++) begin
      for (int i = 0; i < NCH_B; i++) wbb[i] = FB_B'($urandom());
      for (int j = 0; j < FB_B; j++) begin
        @(negedge MCLK);
        ndrdy_b = (j >= 4);
        for (int i = 0; i < NCH_B; i++) dout_b[i] = wbb[i][FB_B-1-j];
      end
      repeat (3) @(negedge MCLK);
      checkOutput("b_valid_pre", 64'(data_valid_b), 64'(0));
      @(negedge MCLK);
      checkOutput("b_valid", 64'(data_valid_b), 64'(1));
      for (int i = 0; i < NCH_B; i++)
        checkOutput($sformatf("b_data%0d", i), 64'(data_b[i]), 64'(wbb[i]));
      checkOutput("b_cnt", 64'(frame_cnt_b), 64'((f + 1) % (1 << CW_B)));
      checkOutput("b_flags", 64'({overrun_b, sync_err_b}), 64'(0));
      @(negedge MCLK);
      checkOutput("b_valid_post", 64'(data_valid_b), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
